// File: rtl/collatz_pkg.sv
// Shared types for the Collatz sequencer: FSM states and result status codes.
// Imported by collatz_step and collatz_runner.
package collatz_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_OVF     = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_ZERO    = 2'd3;

    // Status for a run that stops in RUN; reaching 1 outranks overflow.
    function automatic logic [1:0] end_status(input logic one, input logic ovf);
        if (one)
            return ST_OK;
        else if (ovf)
            return ST_OVF;
        else
            return ST_TIMEOUT;
    endfunction

endpackage

// File: rtl/collatz_step.sv
// Single combinational Collatz step: n/2 for even n, 3n+1 for odd n.
// The odd path is built two bits wider so overflow shows in the top bits.
module collatz_step
    import collatz_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] next,
    output logic             ovf
);

    localparam int XW = WIDTH + 2;

    logic [XW-1:0] triple;
    logic [XW-1:0] wide;

    assign triple = {2'b00, cur} + {1'b0, cur, 1'b0} + XW'(1);

    // Select the step result and flag an odd step that leaves WIDTH bits.
    always_comb begin
        wide = cur[0] ? triple : XW'(cur >> 1);
        next = wide[WIDTH-1:0];
        ovf  = cur[0] & (|wide[XW-1:WIDTH]);
    end

endmodule

// File: rtl/collatz_runner.sv
// Iterates a seed through the Collatz map, reporting steps, peak and status.
// Define COLLATZ_TRACE_EN to add the trace_valid/trace_val streaming tap.
module collatz_runner
    import collatz_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_seed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [STEP_W-1:0] out_steps,
    output logic [WIDTH-1:0]  out_peak,
    output logic [1:0]        out_status,
`ifdef COLLATZ_TRACE_EN
    output logic              trace_valid,
    output logic [WIDTH-1:0]  trace_val,
`endif
    output logic              busy
);

    localparam logic [STEP_W-1:0] STEP_MAX = '1;

    state_t            state;
    logic [WIDTH-1:0]  cur;
    logic [WIDTH-1:0]  peak;
    logic [STEP_W-1:0] steps;
    logic [WIDTH-1:0]  next;
    logic              ovf;
    logic              is_one;
    logic              timeout;
    logic              stop;
    logic              do_step;

    collatz_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .cur (cur),
        .next(next),
        .ovf (ovf)
    );

    // Termination checks for the current RUN cycle, in priority order.
    always_comb begin
        is_one  = (cur == WIDTH'(1));
        timeout = (steps == STEP_MAX);
        stop    = is_one | ovf | timeout;
        do_step = (state == RUN) & ~stop;
    end

    assign in_ready = (state == IDLE);

`ifdef COLLATZ_TRACE_EN
    assign trace_valid = do_step;
    assign trace_val   = do_step ? next : '0;
`endif

    // Sequencer FSM; result outputs only change when entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur        <= '0;
            peak       <= '0;
            steps      <= '0;
            out_steps  <= '0;
            out_peak   <= '0;
            out_status <= ST_OK;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        cur   <= in_seed;
                        peak  <= in_seed;
                        steps <= '0;
                        if (in_seed == '0) begin
                            state      <= DONE;
                            out_steps  <= '0;
                            out_peak   <= '0;
                            out_status <= ST_ZERO;
                            out_valid  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        out_valid  <= 1'b1;
                        out_steps  <= steps;
                        out_peak   <= peak;
                        out_status <= end_status(is_one, ovf);
                    end else begin
                        cur   <= next;
                        steps <= steps + STEP_W'(1);
                        if (next > peak)
                            peak <= next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collatz_runner.sv
// Randomised and directed bench for collatz_runner at three configurations.
// Instance 0: 16/10 bits, instance 1: 8/10 bits, instance 2: 16/4 bits.
module tb_collatz_runner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_v [3];
    logic        iv    [3];
    logic        ordy  [3];
    logic [15:0] seed  [3];
    logic        ir    [3];
    logic        ov    [3];
    logic        bz    [3];
    logic [9:0]  st_o  [3];
    logic [15:0] pk_o  [3];
    logic [1:0]  stat  [3];
`ifdef COLLATZ_TRACE_EN
    logic        tv    [3];
    logic [15:0] tval  [3];
`endif

    int n_vec = 0;
    int n_err = 0;
    bit started = 1'b0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W  = (g == 1) ? 8 : 16;
        localparam int SW = (g == 2) ? 4 : 10;
        logic [SW-1:0] s_l;
        logic [W-1:0]  p_l;
`ifdef COLLATZ_TRACE_EN
        logic [W-1:0]  t_l;
        assign tval[g] = 16'(t_l);
`endif
        collatz_runner #(
            .WIDTH (W),
            .STEP_W(SW)
        ) u_dut (
            .clk        (clk),
            .rst        (rst_v[g]),
            .in_valid   (iv[g]),
            .in_ready   (ir[g]),
            .in_seed    (seed[g][W-1:0]),
            .out_valid  (ov[g]),
            .out_ready  (ordy[g]),
            .out_steps  (s_l),
            .out_peak   (p_l),
            .out_status (stat[g]),
`ifdef COLLATZ_TRACE_EN
            .trace_valid(tv[g]),
            .trace_val  (t_l),
`endif
            .busy       (bz[g])
        );
        assign st_o[g] = 10'(s_l);
        assign pk_o[g] = 16'(p_l);
    end

    function automatic int w_of(input int i);
        return (i == 1) ? 8 : 16;
    endfunction

    function automatic int sw_of(input int i);
        return (i == 2) ? 4 : 10;
    endfunction

    // Reference: iterate the map with plain integers.
    function automatic void model(input int s, input int w, input int sw,
                                  output int k, output int pk, output int st);
        longint c;
        longint lim;
        longint smax;
        c    = s;
        k    = 0;
        pk   = s;
        st   = 0;
        lim  = (longint'(1) << w) - 1;
        smax = (longint'(1) << sw) - 1;
        if (s == 0) begin
            st = 3;
            pk = 0;
            return;
        end
        while (1) begin
            if (c == 1) begin st = 0; break; end
            if ((c % 2) == 1 && (3 * c + 1) > lim) begin st = 1; break; end
            if (k == smax) begin st = 2; break; end
            c = (c % 2 == 0) ? c / 2 : 3 * c + 1;
            k++;
            if (c > pk) pk = int'(c);
        end
    endfunction

    function automatic void chk(input string nm, input int i,
                                input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[%0d] cycle %0d: got %0d expected %0d",
                     nm, i, cyc, act, exp);
        end
    endfunction

    bit     pend  [3];
    bit     fresh [3];
    int     t0    [3];
    int     dn    [3];
    int     ek    [3];
    int     epk   [3];
    int     est   [3];
    longint mcur  [3];

    // Compare every instance against the model each cycle, then advance it.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                bit run_c;
                bit step_c;
                int s;
                int k;
                int pk;
                int st;
                longint nx;
                if (pend[i]) begin
                    run_c  = (cyc >= t0[i] + 1) && (cyc < dn[i]);
                    step_c = (cyc >= t0[i] + 1) && (cyc <= t0[i] + ek[i]) &&
                             (est[i] != 3);
                    chk("in_ready", i, int'(ir[i]), 0);
                    chk("busy", i, int'(bz[i]), int'(run_c));
                    chk("out_valid", i, int'(ov[i]), int'(cyc >= dn[i]));
                    if (cyc >= dn[i]) begin
                        chk("out_steps", i, int'(st_o[i]), ek[i]);
                        chk("out_peak", i, int'(pk_o[i]), epk[i]);
                        chk("out_status", i, int'(stat[i]), est[i]);
                    end
`ifdef COLLATZ_TRACE_EN
                    chk("trace_valid", i, int'(tv[i]), int'(step_c));
                    if (step_c) begin
                        nx = (mcur[i] % 2 == 0) ? mcur[i] / 2 : 3 * mcur[i] + 1;
                        chk("trace_val", i, int'(tval[i]), int'(nx));
                        mcur[i] = nx;
                    end
`endif
                end else begin
                    chk("in_ready", i, int'(ir[i]), 1);
                    chk("busy", i, int'(bz[i]), 0);
                    chk("out_valid", i, int'(ov[i]), 0);
                    if (fresh[i]) begin
                        chk("rst_steps", i, int'(st_o[i]), 0);
                        chk("rst_peak", i, int'(pk_o[i]), 0);
                        chk("rst_status", i, int'(stat[i]), 0);
                    end
`ifdef COLLATZ_TRACE_EN
                    chk("trace_valid", i, int'(tv[i]), 0);
`endif
                end
                if (rst_v[i]) begin
                    pend[i]  = 1'b0;
                    fresh[i] = 1'b1;
                end else if (pend[i] && cyc >= dn[i] && ordy[i]) begin
                    pend[i] = 1'b0;
                end else if (!pend[i] && iv[i]) begin
                    s = int'(seed[i]) & ((1 << w_of(i)) - 1);
                    model(s, w_of(i), sw_of(i), k, pk, st);
                    ek[i]    = k;
                    epk[i]   = pk;
                    est[i]   = st;
                    t0[i]    = cyc;
                    dn[i]    = (s == 0) ? cyc + 1 : cyc + 2 + k;
                    mcur[i]  = s;
                    pend[i]  = 1'b1;
                    fresh[i] = 1'b0;
                end
            end
        end
    end

    task automatic bound_fail(input string nm, input int i);
        n_vec++;
        n_err++;
        $display("FAIL %s[%0d] cycle %0d: wait expired, required within 3000 cycles",
                 nm, i, cyc);
    endtask

    task automatic send(input int i, input int s, input bit hold);
        int n;
        n = 0;
        seed[i] = 16'(s);
        iv[i]   = 1'b1;
        while (!ir[i] && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) bound_fail("accept_wait", i);
        @(posedge clk); #1;
        iv[i] = 1'b0;
        n = 0;
        while (!ov[i] && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) bound_fail("result_wait", i);
        if (hold) begin
            ordy[i] = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            ordy[i] = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int k;
        int pk;
        int st;

        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b1;
            iv[i]    = 1'b0;
            ordy[i]  = 1'b1;
            seed[i]  = '0;
            pend[i]  = 1'b0;
            fresh[i] = 1'b1;
        end

        model(6, 16, 10, k, pk, st);
        chk("model6_steps", 0, k, 8);
        chk("model6_peak", 0, pk, 16);
        chk("model6_status", 0, st, 0);
        model(27, 16, 10, k, pk, st);
        chk("model27_steps", 0, k, 111);
        chk("model27_peak", 0, pk, 9232);
        model(255, 8, 10, k, pk, st);
        chk("model255_steps", 1, k, 0);
        chk("model255_status", 1, st, 1);
        model(27, 16, 4, k, pk, st);
        chk("model27t_steps", 2, k, 15);
        chk("model27t_status", 2, st, 2);
        model(0, 16, 10, k, pk, st);
        chk("model0_status", 0, st, 3);

        @(posedge clk); #1;
        started = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
        @(posedge clk); #1;

        send(0, 6, 1'b0);
        send(0, 27, 1'b0);
        send(0, 0, 1'b0);
        send(0, 1, 1'b0);
        send(0, 6, 1'b1);
        send(1, 255, 1'b0);
        send(1, 7, 1'b0);
        send(2, 27, 1'b0);

        seed[0] = 16'd27;
        iv[0]   = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_v[0] = 1'b1;
        @(posedge clk); #1;
        rst_v[0] = 1'b0;
        @(posedge clk); #1;
        send(0, 6, 1'b0);

        repeat (4000) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                ordy[i]  = ($urandom % 4) != 0;
                rst_v[i] = ($urandom % 600) == 0;
                iv[i]    = ($urandom % 3) == 0;
                if (i == 1)
                    seed[i] = 16'($urandom % 256);
                else if (($urandom % 4) == 0)
                    seed[i] = 16'($urandom % 65536);
                else
                    seed[i] = 16'($urandom % 200);
            end
        end

        for (int i = 0; i < 3; i++) begin
            iv[i]    = 1'b0;
            rst_v[i] = 1'b0;
            ordy[i]  = 1'b1;
        end
        repeat (5) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
